led_pattern_gen: RTL and testbench



---
 rtl/led_pattern_pkg.sv | 16 +
 rtl/led_pattern_gen_channel.sv | 88 ++++++++
 rtl/led_pattern_gen.sv | 43 ++++
 tb/tb_led_pattern_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and sizing helper for the LED pattern generator.
package led_pattern_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF   = 2'b00;
  localparam mode_t MODE_ON    = 2'b01;
  localparam mode_t MODE_BLINK = 2'b10;
  localparam mode_t MODE_PWM   = 2'b11;

  // Channel-select width: at least one bit even for a single channel.
  function automatic int unsigned ch_w(input int unsigned n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: config registers, private counters, registered led/tick.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int unsigned PER_W    = 25,
  parameter int unsigned DUTY_W   = 8,
  parameter mode_t       RST_MODE = MODE_OFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  mode_t             cfg_mode,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic              led,
  output logic              tick
);

  localparam logic RST_LED = (RST_MODE == MODE_ON) || (RST_MODE == MODE_BLINK);

  mode_t             mode_q;
  logic [PER_W-1:0]  period_q;
  logic [DUTY_W-1:0] duty_q;
  logic [PER_W-1:0]  cnt_q;
  logic [DUTY_W-1:0] pcnt_q;
  logic              led_q;
  logic              tick_q;

  logic              load_led;
  logic [DUTY_W-1:0] pcnt_inc;

  // LED level taken on a config load; BLINK starts in its high phase.
  always_comb begin
    load_led = 1'b0;
    case (cfg_mode)
      MODE_ON:    load_led = 1'b1;
      MODE_BLINK: load_led = 1'b1;
      MODE_PWM:   load_led = (cfg_duty != '0);
      default:    load_led = 1'b0;
    endcase
  end

  assign pcnt_inc = pcnt_q + DUTY_W'(1);

  // Channel state: reset beats load, load beats free-running pattern update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= RST_MODE;
      period_q <= '0;
      duty_q   <= '0;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      led_q    <= RST_LED;
      tick_q   <= 1'b0;
    end else if (load) begin
      mode_q   <= cfg_mode;
      period_q <= cfg_period;
      duty_q   <= cfg_duty;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      led_q    <= load_led;
      tick_q   <= 1'b0;
    end else begin
      case (mode_q)
        MODE_BLINK: begin
          if (cnt_q == period_q) begin
            cnt_q  <= '0;
            led_q  <= ~led_q;
            tick_q <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + PER_W'(1);
            tick_q <= 1'b0;
          end
        end
        MODE_PWM: begin
          pcnt_q <= pcnt_inc;
          led_q  <= (pcnt_inc < duty_q);
          tick_q <= &pcnt_q;
        end
        default: tick_q <= 1'b0;
      endcase
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM with strobed config writes.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned PER_W    = 25,
  parameter int unsigned DUTY_W   = 8,
  parameter mode_t       RST_MODE = MODE_OFF,
  localparam int unsigned CH_W    = ch_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   tick
);

  // One independent channel per LED; selects beyond N_CH match no instance.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic load;
    assign load = cfg_we && (cfg_ch == CH_W'(i));

    led_channel #(
      .PER_W    (PER_W),
      .DUTY_W   (DUTY_W),
      .RST_MODE (RST_MODE)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .led        (led[i]),
      .tick       (tick[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: a cycle-count model predicts led/tick for three configurations.
module tb_led_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // Instance A: defaults, RST_MODE=OFF
  logic        we_a;
  logic [1:0]  ch_a;
  logic [1:0]  mode_a;
  logic [24:0] per_a;
  logic [7:0]  duty_a;
  logic [3:0]  led_a, tick_a;
  // Instance B: RST_MODE=ON, never written
  logic        we_b;
  logic [3:0]  led_b, tick_b;
  // Instance C: N_CH=1, PER_W=4, DUTY_W=3
  logic        we_c;
  logic [0:0]  ch_c;
  logic [1:0]  mode_c;
  logic [3:0]  per_c;
  logic [2:0]  duty_c;
  logic [0:0]  led_c, tick_c;

  led_pattern_gen #(.N_CH(4), .PER_W(25), .DUTY_W(8), .RST_MODE(2'b00)) u_a (
    .clk(clk), .rst_n(rst_n), .cfg_we(we_a), .cfg_ch(ch_a), .cfg_mode(mode_a),
    .cfg_period(per_a), .cfg_duty(duty_a), .led(led_a), .tick(tick_a));

  led_pattern_gen #(.N_CH(4), .PER_W(25), .DUTY_W(8), .RST_MODE(2'b01)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_we(we_b), .cfg_ch(ch_a), .cfg_mode(mode_a),
    .cfg_period(per_a), .cfg_duty(duty_a), .led(led_b), .tick(tick_b));

  led_pattern_gen #(.N_CH(1), .PER_W(4), .DUTY_W(3), .RST_MODE(2'b00)) u_c (
    .clk(clk), .rst_n(rst_n), .cfg_we(we_c), .cfg_ch(ch_c), .cfg_mode(mode_c),
    .cfg_period(per_c), .cfg_duty(duty_c), .led(led_c), .tick(tick_c));

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] c;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;
  int hi_cnt   = 0;
  int tk_cnt   = 0;

  // Model state per channel: mode, period, duty, edges since last load/reset
  logic [1:0] ma_mode[4];
  longint     ma_per[4];
  int         ma_duty[4];
  int         ma_n[4];
  logic [1:0] mc_mode;
  longint     mc_per;
  int         mc_duty;
  int         mc_n;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Expected {led,tick} n edges after a load, from elapsed time alone
  function automatic logic [1:0] model_out(input logic [1:0] mode, input longint per,
                                           input int duty, input int n, input int frame);
    logic l, t;
    l = 1'b0;
    t = 1'b0;
    case (mode)
      2'b01: l = 1'b1;
      2'b10: begin
        l = ((n / (per + 1)) % 2) == 0;
        t = (n > 0) && ((n % (per + 1)) == 0);
      end
      2'b11: begin
        l = (n % frame) < duty;
        t = (n > 0) && ((n % frame) == 0);
      end
      default: ;
    endcase
    return {l, t};
  endfunction

  task automatic cycle();
    exp_t e;
    exp_t got;
    logic [1:0] o;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        ma_mode[i] = 2'b00; ma_per[i] = 0; ma_duty[i] = 0; ma_n[i] = 0;
      end else if (we_a && (int'(ch_a) == i)) begin
        ma_mode[i] = mode_a; ma_per[i] = longint'(per_a); ma_duty[i] = int'(duty_a); ma_n[i] = 0;
      end else begin
        ma_n[i]++;
      end
    end
    if (!rst_n) begin
      mc_mode = 2'b00; mc_per = 0; mc_duty = 0; mc_n = 0;
    end else if (we_c && ch_c == 1'b0) begin
      mc_mode = mode_c; mc_per = longint'(per_c); mc_duty = int'(duty_c); mc_n = 0;
    end else begin
      mc_n++;
    end
    e = '0;
    for (int i = 0; i < 4; i++) begin
      o = model_out(ma_mode[i], ma_per[i], ma_duty[i], ma_n[i], 256);
      e.a[4+i] = o[1];
      e.a[i]   = o[0];
    end
    e.b = 8'hF0;
    e.c = model_out(mc_mode, mc_per, mc_duty, mc_n, 8);
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
    end else begin
      got = sb.pop_front();
      check("inst_a", 32'({led_a, tick_a}), 32'(got.a));
      check("inst_b", 32'({led_b, tick_b}), 32'(got.b));
      check("inst_c", 32'({led_c, tick_c}), 32'(got.c));
    end
    hi_cnt += int'(led_a[1]);
    tk_cnt += int'(tick_a[1]);
    we_a = 1'b0;
    we_c = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr_a(input logic [1:0] ch, input logic [1:0] mode, input int per, input int duty);
    we_a = 1'b1; ch_a = ch; mode_a = mode; per_a = 25'(per); duty_a = 8'(duty);
    cycle();
  endtask

  task automatic wr_c(input logic [0:0] ch, input logic [1:0] mode, input int per, input int duty);
    we_c = 1'b1; ch_c = ch; mode_c = mode; per_c = 4'(per); duty_c = 3'(duty);
    cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    we_a = 1'b0; ch_a = '0; mode_a = '0; per_a = '0; duty_a = '0;
    we_b = 1'b0;
    we_c = 1'b0; ch_c = '0; mode_c = '0; per_c = '0; duty_c = '0;
    for (int i = 0; i < 4; i++) begin
      ma_mode[i] = 2'b00; ma_per[i] = 0; ma_duty[i] = 0; ma_n[i] = 0;
    end
    mc_mode = 2'b00; mc_per = 0; mc_duty = 0; mc_n = 0;
    @(negedge clk);

    // Reset held three cycles, then idle
    run(3);
    rst_n = 1'b1;
    run(3);

    // BLINK period 3, then period 0
    wr_a(2'd0, 2'b10, 3, 0);
    run(20);
    wr_a(2'd0, 2'b10, 0, 0);
    run(6);

    // PWM duty 64: 64 high and one tick per 256-cycle frame
    wr_a(2'd1, 2'b11, 0, 64);
    hi_cnt = 0; tk_cnt = 0;
    run(256);
    check("pwm64_high", 32'(hi_cnt), 32'(64));
    check("pwm64_tick", 32'(tk_cnt), 32'(1));
    run(10);

    // PWM duty 0 never high
    wr_a(2'd1, 2'b11, 0, 0);
    hi_cnt = 0;
    run(256);
    check("pwm0_high", 32'(hi_cnt), 32'(0));

    // PWM duty 255 low exactly one cycle per frame
    wr_a(2'd1, 2'b11, 0, 255);
    hi_cnt = 0;
    run(256);
    check("pwm255_high", 32'(hi_cnt), 32'(255));

    // Isolation and resync on ch0 BLINK period 5
    wr_a(2'd0, 2'b10, 5, 0);
    run(7);
    wr_a(2'd2, 2'b01, 0, 0);
    run(5);
    wr_a(2'd0, 2'b10, 5, 0);
    run(10);

    // Small instance: BLINK 16/16, PWM 3 of 8, out-of-range channel ignored
    wr_c(1'b0, 2'b10, 15, 0);
    run(40);
    wr_c(1'b0, 2'b11, 0, 3);
    run(20);
    wr_c(1'b1, 2'b01, 0, 0);
    run(10);

    // All channels running, then reset coincident with a write
    wr_a(2'd3, 2'b11, 0, 100);
    run(5);
    rst_n = 1'b0;
    we_a = 1'b1; ch_a = 2'd2; mode_a = 2'b10; per_a = 25'd2; duty_a = 8'd0;
    cycle();
    rst_n = 1'b1;
    run(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
